// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline: load-use bubbles,
// memory wait-state freezes, taken-branch flushes, performance counters and hang flag.

package regfilemux;
  typedef enum logic [3:0] {
    alu_out  = 4'b0000,
    br_en    = 4'b0001,
    u_imm    = 4'b0010,
    lw       = 4'b0011,
    pc_plus4 = 4'b0100,
    lb       = 4'b0101,
    lbu      = 4'b0110,
    lh       = 4'b0111,
    lhu      = 4'b1000
  } regfilemux_sel_t;
endpackage

module hazard_stall_ctrl #(
  parameter int HANG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  regfilemux::regfilemux_sel_t ID_EX_regfile_sel,
  input  logic [4:0]                 ID_EX_rd,
  input  logic                       ID_EX_load_regfile,
  input  logic [4:0]                 IF_ID_rs1,
  input  logic [4:0]                 IF_ID_rs2,
  input  logic                       IF_ID_use_rs1,
  input  logic                       IF_ID_use_rs2,
  input  logic                       br_taken,
  input  logic                       imem_resp,
  input  logic                       dmem_req,
  input  logic                       dmem_resp,
  output logic                       load_pc,
  output logic                       load_if_id,
  output logic                       load_id_ex,
  output logic                       load_ex_mem,
  output logic                       load_mem_wb,
  output logic                       flush_if_id,
  output logic                       flush_id_ex,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           lu_cnt,
  output logic [CNT_W-1:0]           flush_cnt,
  output logic                       hang
);

  localparam int RUN_W = $clog2(HANG_LIMIT) + 1;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(HANG_LIMIT);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_STALL} state_t;

  state_t           state_q, state_d;
  logic             lu_done_q, lu_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             hang_q, hang_d;

  logic is_load, lu_haz, mem_wait;

  always_comb begin
    is_load  = ID_EX_regfile_sel inside {regfilemux::lw, regfilemux::lb, regfilemux::lbu,
                                         regfilemux::lh, regfilemux::lhu};
    lu_haz   = is_load && ID_EX_load_regfile && (ID_EX_rd != 5'd0) &&
               ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));
    mem_wait = !imem_resp || (dmem_req && !dmem_resp);
  end

  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    state_d     = state_q;
    lu_done_d   = lu_done_q;
    stall_cnt_d = stall_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_cnt_d   = run_cnt_q;
    hang_d      = hang_q;

    if (rst) begin
      if (mem_wait) begin
        // Freeze everything; lu_done is untouched so a pending bubble resumes afterward.
        state_d     = MEM_STALL;
        stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
        run_cnt_d   = (run_cnt_q == RUN_LIMIT) ? run_cnt_q : run_cnt_q + 1'b1;
      end else begin
        run_cnt_d = '0;
        if (br_taken) begin
          {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = '1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = RUN;
          lu_done_d   = 1'b0;
          flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + 1'b1;
        end else if (lu_haz && (state_q != LOAD_STALL) && !lu_done_q) begin
          load_id_ex  = 1'b1;
          flush_id_ex = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
          state_d     = LOAD_STALL;
          lu_done_d   = 1'b1;
          lu_cnt_d    = (lu_cnt_q == '1) ? lu_cnt_q : lu_cnt_q + 1'b1;
        end else begin
          {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = '1;
          state_d   = RUN;
          lu_done_d = 1'b0;
        end
      end
      if (run_cnt_d == RUN_LIMIT) hang_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      lu_done_q   <= 1'b0;
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
      run_cnt_q   <= '0;
      hang_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lu_done_q   <= lu_done_d;
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_cnt_q   <= run_cnt_d;
      hang_q      <= hang_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign lu_cnt    = lu_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign hang      = hang_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with HANG_LIMIT = 4.

module tb_hazard_stall_ctrl;

  logic                        clk;
  logic                        rst;
  regfilemux::regfilemux_sel_t ID_EX_regfile_sel;
  logic [4:0]                  ID_EX_rd;
  logic                        ID_EX_load_regfile;
  logic [4:0]                  IF_ID_rs1, IF_ID_rs2;
  logic                        IF_ID_use_rs1, IF_ID_use_rs2;
  logic                        br_taken, imem_resp, dmem_req, dmem_resp;
  logic                        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic                        flush_if_id, flush_id_ex;
  logic [31:0]                 stall_cnt, lu_cnt, flush_cnt;
  logic                        hang;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  hazard_stall_ctrl #(.HANG_LIMIT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_regfile_sel(ID_EX_regfile_sel), .ID_EX_rd(ID_EX_rd),
    .ID_EX_load_regfile(ID_EX_load_regfile),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .br_taken(br_taken), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt), .hang(hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] loads, input logic [1:0] fl);
    check({tag, "_loads"}, {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, loads);
    check({tag, "_flush"}, {flush_if_id, flush_id_ex}, fl);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ID_EX_regfile_sel  = regfilemux::alu_out;
    ID_EX_rd           = 5'd0;
    ID_EX_load_regfile = 1'b0;
    IF_ID_rs1          = 5'd0;
    IF_ID_rs2          = 5'd0;
    IF_ID_use_rs1      = 1'b0;
    IF_ID_use_rs2      = 1'b0;
    br_taken           = 1'b0;
    imem_resp          = 1'b1;
    dmem_req           = 1'b0;
    dmem_resp          = 1'b0;
  endtask

  task automatic set_ex(input regfilemux::regfilemux_sel_t sel, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    ID_EX_regfile_sel  = sel;
    ID_EX_rd           = rd;
    ID_EX_load_regfile = 1'b1;
    IF_ID_rs1          = rs1;
    IF_ID_use_rs1      = u1;
    IF_ID_rs2          = rs2;
    IF_ID_use_rs2      = u2;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check_ctl("rst_hold", 5'b00000, 2'b00);
    end
    rst = 1'b1;
    #1;
    check_ctl("post_rst", 5'b11111, 2'b00);
    check("post_rst_cnt", {stall_cnt, lu_cnt}, 64'd0);
    check("post_rst_flushcnt", flush_cnt, 32'd0);
    check("post_rst_hang", hang, 1'b0);

    // Load-use on rs2, inputs held: exactly one bubble
    tick();
    set_ex(regfilemux::lw, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    #1;
    check_ctl("lu_bubble", 5'b00111, 2'b01);
    tick();
    #1;
    check_ctl("lu_after", 5'b11111, 2'b00);
    check("lu_cnt_1", lu_cnt, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("lu_cnt_hold", lu_cnt, 32'd1);

    // No hazard for lw to x0 or for non-load writer
    tick();
    set_ex(regfilemux::lw, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check_ctl("lw_x0", 5'b11111, 2'b00);
    tick();
    set_ex(regfilemux::alu_out, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check_ctl("alu_x5", 5'b11111, 2'b00);
    tick();
    set_ex(regfilemux::lhu, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    #1;
    check_ctl("lhu_unused_rs", 5'b11111, 2'b00);
    tick();
    idle_inputs();
    #1;
    check("no_haz_lu_cnt", lu_cnt, 32'd1);

    // Data memory wait for 3 cycles during a load-use, then one bubble
    set_ex(regfilemux::lb, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    dmem_req  = 1'b1;
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctl("dwait", 5'b00000, 2'b00);
      tick();
    end
    dmem_resp = 1'b1;
    #1;
    check_ctl("dwait_bubble", 5'b00111, 2'b01);
    tick();
    idle_inputs();
    #1;
    check_ctl("dwait_resume", 5'b11111, 2'b00);
    check("dwait_stall_cnt", stall_cnt, 32'd3);
    check("dwait_lu_cnt", lu_cnt, 32'd2);

    // Taken branch with coincident load-use: flush wins
    tick();
    set_ex(regfilemux::lw, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    br_taken = 1'b1;
    #1;
    check_ctl("br_lu", 5'b11111, 2'b11);
    tick();
    idle_inputs();
    #1;
    check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_lu_cnt", lu_cnt, 32'd2);

    // Branch during instruction wait is honored once afterward
    br_taken  = 1'b1;
    imem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_ctl("br_iwait", 5'b00000, 2'b00);
      tick();
    end
    imem_resp = 1'b1;
    #1;
    check_ctl("br_release", 5'b11111, 2'b11);
    tick();
    idle_inputs();
    #1;
    check("br_release_cnt", {stall_cnt, flush_cnt}, {32'd5, 32'd2});

    // Hang after 4 consecutive wait cycles, sticky until reset
    check("hang_pre", hang, 1'b0);
    imem_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hang_run", hang, (i == 4) ? 1'b1 : 1'b0);
      tick();
    end
    imem_resp = 1'b1;
    #1;
    check("hang_sticky", hang, 1'b1);
    check_ctl("hang_noctl", 5'b11111, 2'b00);
    check("hang_stall_cnt", stall_cnt, 32'd10);

    // Reset mid-stall with a pending load-use discards everything
    set_ex(regfilemux::lh, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    dmem_req = 1'b1;
    dmem_resp = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_ctl("rst_mid", 5'b00000, 2'b00);
    tick();
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst2_hang", hang, 1'b0);
    check("rst2_cnt", {stall_cnt, lu_cnt}, 64'd0);
    check("rst2_flushcnt", flush_cnt, 32'd0);
    check_ctl("rst2_ctl", 5'b11111, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. Generates the load enables and flush/bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Covers three cases: load-use hazards that forwarding cannot cover, instruction and data memory wait states, and taken-branch flushes. Also keeps saturating stall/flush performance counters and a sticky memory-hang flag.

## Interface
- `HANG_LIMIT`, default 1024: consecutive MEM_STALL cycles after which `hang` is set.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-low.
- `ID_EX_regfile_sel` in `regfilemux::regfilemux_sel_t`: writeback select of the instruction in EX.
- `ID_EX_rd` in 5: destination register of the instruction in EX.
- `ID_EX_load_regfile` in 1: the instruction in EX writes the register file.
- `IF_ID_rs1`, `IF_ID_rs2` in 5 each: source registers of the instruction in ID.
- `IF_ID_use_rs1`, `IF_ID_use_rs2` in 1 each: the instruction in ID reads rs1/rs2.
- `br_taken` in 1: branch or jump resolved taken in EX.
- `imem_resp` in 1: instruction fetch completes this cycle.
- `dmem_req` in 1: the instruction in MEM issues a load or store.
- `dmem_resp` in 1: data access completes this cycle.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: register enables.
- `flush_if_id`, `flush_id_ex` out 1 each: load a NOP into the register on this edge. Only valid together with the matching load.
- `stall_cnt`, `lu_cnt`, `flush_cnt` out `CNT_W` each: saturating counts of memory-stall cycles, load-use bubbles and branch flushes.
- `hang` out 1: sticky memory-hang flag.

## Operation
- Load detect: `ID_EX_regfile_sel` is one of lw, lb, lbu, lh, lhu.
- Load-use hazard (`lu_haz`) requires all of:
  - load detect;
  - `ID_EX_load_regfile`;
  - `ID_EX_rd != 0`;
  - `(IF_ID_use_rs1 && IF_ID_rs1 == ID_EX_rd) || (IF_ID_use_rs2 && IF_ID_rs2 == ID_EX_rd)`.
- Memory wait (`mem_wait`): `!imem_resp || (dmem_req && !dmem_resp)`.
- FSM states are RUN, LOAD_STALL and MEM_STALL. Outputs are combinational from state and inputs.
- Control priority, highest first:
  1. `mem_wait`: all five `load_*` are 0 and both flushes are 0. The pipeline freezes, including any pending branch or hazard.
  2. `br_taken`: all loads 1, `flush_if_id` = 1, `flush_id_ex` = 1. A coincident `lu_haz` is ignored, because the dependent instruction is squashed.
  3. `lu_haz` while state != LOAD_STALL: `load_pc` = 0, `load_if_id` = 0, `load_id_ex` = 1 with `flush_id_ex` = 1, `load_ex_mem` = `load_mem_wb` = 1. This inserts one bubble.
  4. Otherwise all loads are 1 and flushes are 0.
- State transitions, evaluated each cycle:
  - If `mem_wait`: next state is MEM_STALL. The state is held where it was, so a LOAD_STALL interrupted by `mem_wait` returns to its pending status afterward. To do this, keep a separate `lu_done` bit that is set when a bubble is inserted and cleared on any cycle where `load_if_id` = 1.
  - Else if case 3 fires: next state is LOAD_STALL and `lu_done` is set.
  - Else: next state is RUN.
- The LOAD_STALL/`lu_done` rule guarantees exactly one bubble per load-use pair. After the bubble the load is in MEM and forwarding covers the dependency. `lu_haz` cannot re-fire for the same pair because ID_EX now holds a NOP.
- Counters saturate at all-ones and never wrap:
  - `stall_cnt` increments on every `mem_wait` cycle.
  - `lu_cnt` increments on each bubble inserted by case 3.
  - `flush_cnt` increments on each case-2 cycle.
- Hang detection:
  - An internal run counter (width clog2(`HANG_LIMIT`)+1) counts consecutive `mem_wait` cycles and clears on any non-wait cycle.
  - When the counter reaches `HANG_LIMIT`, `hang` is set.
  - `hang` stays set until reset. It does not alter control outputs.

## Timing
- Reset (`rst` = 0 at a rising edge): state RUN, `lu_done` = 0, all counters 0, run counter 0, `hang` = 0.
- While `rst` = 0, all `load_*` outputs are 0 and flushes are 0. Reset mid-stall discards the stall; no bubble or flush is pending afterward.
- Control outputs have zero latency (same-cycle combinational). Counters and `hang` update on the edge after the qualifying cycle.
- A load-use costs exactly 1 cycle when memory responds immediately. A taken branch costs 2 cycles (two NOPs).
- `br_taken` arriving during `mem_wait` is honored on the first cycle `mem_wait` drops, with exactly one flush counted.

## Test plan
- Reset with `rst` = 0 for 2 cycles, then release with `imem_resp` = 1 → all outputs 0 during reset; all loads 1, flushes 0 and counters 0 on the first cycle after release.
- ID_EX = lw to x5 and IF_ID reads x5 on rs2 → one cycle with `load_pc` = `load_if_id` = 0 and `flush_id_ex` = 1; the next cycle has all loads 1; `lu_cnt` = 1.
- lw to x0 with IF_ID reading x0, and separately alu_out to x5 with IF_ID reading x5 → no stall; `lu_cnt` stays 0.
- `dmem_req` = 1 with `dmem_resp` low for 3 cycles, during a load-use → all loads 0 for 3 cycles; then exactly one bubble; `stall_cnt` = 3, `lu_cnt` = 1.
- `br_taken` together with `lu_haz` → all loads 1, both flushes 1; `flush_cnt` = 1, `lu_cnt` = 0.
- `HANG_LIMIT` = 4 with `imem_resp` held low for 5 cycles → `hang` rises after the 4th wait cycle, stays 1 after `imem_resp` returns, and clears only on reset.
